prom_arbiter: RTL and testbench

PROM_ARBITER -- requirements
Module: prom_arbiter

---
 rtl/prom_arbiter.sv | 136 +++++++++++++
 tb/tb_prom_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/prom_arbiter.sv
// Two-port arbiter sharing one PROM through an IDLE/SETUP/ACCESS/RELEASE cycle.
// Define PROM_ARB_ROUND_ROBIN_EN for round-robin ties; default is fixed priority to port 0.
module prom_arbiter #(
  parameter int ADDR_WIDTH  = 15,
  parameter int DATA_WIDTH  = 8,
  parameter int WAIT_CYCLES = 3
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  REQ0,
  input  logic [ADDR_WIDTH-1:0] A0,
  output logic                  ACK0,
  output logic [DATA_WIDTH-1:0] D0,
  input  logic                  REQ1,
  input  logic [ADDR_WIDTH-1:0] A1,
  output logic                  ACK1,
  output logic [DATA_WIDTH-1:0] D1,
  output logic [ADDR_WIDTH-1:0] PROM_A,
  output logic                  PROM_E,
  output logic                  PROM_G,
  input  logic [DATA_WIDTH-1:0] PROM_Q,
  output logic                  BUSY
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RELEASE} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t                  state_q, state_d;
  logic                    gnt_q, gnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    ack0_q, ack0_d, ack1_q, ack1_d;
  logic [DATA_WIDTH-1:0]   d0_q, d0_d, d1_q, d1_d;
  logic                    win;
`ifdef PROM_ARB_ROUND_ROBIN_EN
  logic                    ptr_q, ptr_d;
`endif

  // Winner selection; the pointer holds the last granted port
  always_comb begin
    win = REQ1 & ~REQ0;
    if (REQ0 && REQ1) begin
`ifdef PROM_ARB_ROUND_ROBIN_EN
      win = ~ptr_q;
`else
      win = 1'b0;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    d0_d    = d0_q;
    d1_d    = d1_q;
`ifdef PROM_ARB_ROUND_ROBIN_EN
    ptr_d   = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (REQ0 || REQ1) begin
          gnt_d   = win;
          addr_d  = win ? A1 : A0;
          state_d = SETUP;
`ifdef PROM_ARB_ROUND_ROBIN_EN
          ptr_d   = win;
`endif
        end
      end
      SETUP: begin
        cnt_d   = CNT_LOAD;
        state_d = ACCESS;
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          // Capture and ACK are registered so both appear on entry to RELEASE
          if (gnt_q) begin
            d1_d   = PROM_Q;
            ack1_d = 1'b1;
          end else begin
            d0_d   = PROM_Q;
            ack0_d = 1'b1;
          end
          state_d = RELEASE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      addr_q  <= '0;
      cnt_q   <= 4'd0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      d0_q    <= '0;
      d1_q    <= '0;
`ifdef PROM_ARB_ROUND_ROBIN_EN
      ptr_q   <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      d0_q    <= d0_d;
      d1_q    <= d1_d;
`ifdef PROM_ARB_ROUND_ROBIN_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  assign PROM_A = addr_q;
  assign PROM_E = (state_q == SETUP) || (state_q == ACCESS);
  assign PROM_G = (state_q == ACCESS);
  assign BUSY   = (state_q != IDLE);
  assign ACK0   = ack0_q;
  assign ACK1   = ack1_q;
  assign D0     = d0_q;
  assign D1     = d1_q;

endmodule

// File: tb/tb_prom_arbiter.sv
// Directed bench for prom_arbiter: WAIT_CYCLES=3 instance plus a WAIT_CYCLES=1 instance.
module tb_prom_arbiter;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        REQ0 = 1'b0, REQ1 = 1'b0;
  logic [14:0] A0 = '0, A1 = '0;
  logic        ACK0, ACK1, PROM_E, PROM_G, BUSY;
  logic [7:0]  D0, D1, PROM_Q;
  logic [14:0] PROM_A;

  logic        REQ0_w1 = 1'b0, REQ1_w1 = 1'b0;
  logic [14:0] A0_w1 = '0, A1_w1 = '0;
  logic        ACK0_w1, ACK1_w1, PROM_E_w1, PROM_G_w1, BUSY_w1;
  logic [7:0]  D0_w1, D1_w1, PROM_Q_w1;
  logic [14:0] PROM_A_w1;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  function automatic logic [7:0] mem(input logic [14:0] a);
    if (a == 15'h0010) return 8'h5A;
    return 8'(a[7:0] * 8'd3 + 8'd7);
  endfunction

  assign PROM_Q    = mem(PROM_A);
  assign PROM_Q_w1 = mem(PROM_A_w1);

  prom_arbiter #(.ADDR_WIDTH(15), .DATA_WIDTH(8), .WAIT_CYCLES(3)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .REQ0(REQ0), .A0(A0), .ACK0(ACK0), .D0(D0),
    .REQ1(REQ1), .A1(A1), .ACK1(ACK1), .D1(D1),
    .PROM_A(PROM_A), .PROM_E(PROM_E), .PROM_G(PROM_G), .PROM_Q(PROM_Q),
    .BUSY(BUSY)
  );

  prom_arbiter #(.ADDR_WIDTH(15), .DATA_WIDTH(8), .WAIT_CYCLES(1)) dut_w1 (
    .CLK(CLK), .RST_N(RST_N),
    .REQ0(REQ0_w1), .A0(A0_w1), .ACK0(ACK0_w1), .D0(D0_w1),
    .REQ1(REQ1_w1), .A1(A1_w1), .ACK1(ACK1_w1), .D1(D1_w1),
    .PROM_A(PROM_A_w1), .PROM_E(PROM_E_w1), .PROM_G(PROM_G_w1), .PROM_Q(PROM_Q_w1),
    .BUSY(BUSY_w1)
  );

  task automatic do_reset();
    REQ0 = 1'b0; REQ1 = 1'b0; REQ0_w1 = 1'b0; REQ1_w1 = 1'b0;
    RST_N = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RST_N = 1'b1;
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    #3;
    checks++;
    if ({PROM_E, PROM_G, BUSY, ACK0, ACK1} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl got %b want 00000", {PROM_E, PROM_G, BUSY, ACK0, ACK1});
    end
    checks++;
    if ({PROM_A, D0, D1} !== 31'h0) begin
      errors++; $display("FAIL reset_data got A=%0h D0=%0h D1=%0h want 0", PROM_A, D0, D1);
    end
    do_reset();
  endtask

  task automatic test_single_read();
    do_reset();
    A0 = 15'h0010; REQ0 = 1'b1;
    @(posedge CLK); #1;
    REQ0 = 1'b0;
    checks++;
    if ({BUSY, PROM_E, PROM_G} !== 3'b110 || PROM_A !== 15'h0010) begin
      errors++; $display("FAIL sr_setup got BEG=%b A=%0h want 110 A=10", {BUSY, PROM_E, PROM_G}, PROM_A);
    end
    @(posedge CLK); #1;
    checks++;
    if ({PROM_E, PROM_G} !== 2'b11) begin
      errors++; $display("FAIL sr_access got EG=%b want 11", {PROM_E, PROM_G});
    end
    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if ({PROM_G, ACK0, ACK1} !== 3'b100 || D0 !== 8'h00) begin
      errors++; $display("FAIL sr_wait got G/ACK=%b D0=%0h want 100 D0=0", {PROM_G, ACK0, ACK1}, D0);
    end
    @(posedge CLK); #1;
    checks++;
    if ({ACK0, ACK1, PROM_E, PROM_G, BUSY} !== 5'b10001) begin
      errors++; $display("FAIL sr_release got %b want 10001", {ACK0, ACK1, PROM_E, PROM_G, BUSY});
    end
    checks++;
    if (D0 !== 8'h5A || PROM_A !== 15'h0010) begin
      errors++; $display("FAIL sr_data got D0=%0h A=%0h want 5a A=10", D0, PROM_A);
    end
    @(posedge CLK); #1;
    checks++;
    if ({ACK0, BUSY} !== 2'b00 || D0 !== 8'h5A) begin
      errors++; $display("FAIL sr_idle got ACK0/BUSY=%b D0=%0h want 00 5a", {ACK0, BUSY}, D0);
    end
  endtask

  task automatic test_tie();
    int exp_port;
    bit seen;
    do_reset();
    A0 = 15'h0001; A1 = 15'h0002; REQ0 = 1'b1; REQ1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
`ifdef PROM_ARB_ROUND_ROBIN_EN
      exp_port = k % 2;
`else
      exp_port = 0;
`endif
      @(posedge CLK); #1;
      if (k > 0) begin
        checks++;
        if ({ACK0, ACK1} !== 2'b00) begin
          errors++; $display("FAIL tie_pulse%0d got %b want 00", k, {ACK0, ACK1});
        end
      end
      seen = 1'b0;
      for (int c = 0; c < 20; c++) begin
        if (ACK0 || ACK1) begin
          seen = 1'b1;
          break;
        end
        @(posedge CLK); #1;
      end
      checks++;
      if (!seen) begin
        errors++; $display("FAIL tie_timeout%0d got no ack want ack", k);
      end else if (exp_port == 0 && ({ACK0, ACK1} !== 2'b10 || D0 !== 8'h0A)) begin
        errors++; $display("FAIL tie_port%0d got ACK=%b D0=%0h want 10 0a", k, {ACK0, ACK1}, D0);
      end else if (exp_port == 1 && ({ACK0, ACK1} !== 2'b01 || D1 !== 8'h0D)) begin
        errors++; $display("FAIL tie_port%0d got ACK=%b D1=%0h want 01 0d", k, {ACK0, ACK1}, D1);
      end
    end
    REQ0 = 1'b0; REQ1 = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
  endtask

  task automatic test_late_requester();
    do_reset();
    A0 = 15'h0010; REQ0 = 1'b1;
    @(posedge CLK); #1;
    REQ0 = 1'b0;
    @(posedge CLK); #1;
    A1 = 15'h0020; REQ1 = 1'b1;
    repeat (2) begin
      @(posedge CLK); #1;
      checks++;
      if (PROM_A !== 15'h0010 || ACK1 !== 1'b0) begin
        errors++; $display("FAIL late_hold got A=%0h ACK1=%b want 10 0", PROM_A, ACK1);
      end
    end
    @(posedge CLK); #1;
    checks++;
    if ({ACK0, ACK1} !== 2'b10 || PROM_A !== 15'h0010) begin
      errors++; $display("FAIL late_rel0 got ACK=%b A=%0h want 10 A=10", {ACK0, ACK1}, PROM_A);
    end
    @(posedge CLK); #1;
    checks++;
    if (BUSY !== 1'b0 || PROM_A !== 15'h0010) begin
      errors++; $display("FAIL late_idle got BUSY=%b A=%0h want 0 A=10", BUSY, PROM_A);
    end
    @(posedge CLK); #1;
    checks++;
    if (BUSY !== 1'b1 || PROM_A !== 15'h0020) begin
      errors++; $display("FAIL late_grant1 got BUSY=%b A=%0h want 1 A=20", BUSY, PROM_A);
    end
    REQ1 = 1'b0; A1 = 15'h0030;
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if (PROM_A !== 15'h0020 || ACK1 !== 1'b0) begin
      errors++; $display("FAIL late_addr_ignore got A=%0h ACK1=%b want 20 0", PROM_A, ACK1);
    end
    @(posedge CLK); #1;
    checks++;
    if ({ACK0, ACK1} !== 2'b01 || D1 !== 8'h67 || D0 !== 8'h5A) begin
      errors++; $display("FAIL late_ack1 got ACK=%b D1=%0h D0=%0h want 01 67 5a", {ACK0, ACK1}, D1, D0);
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_reset_mid_access();
    do_reset();
    A0 = 15'h0010; REQ0 = 1'b1;
    @(posedge CLK); #1;
    REQ0 = 1'b0;
    repeat (5) @(posedge CLK);
    #1;
    A0 = 15'h0011; REQ0 = 1'b1;
    @(posedge CLK); #1;
    REQ0 = 1'b0;
    @(posedge CLK); #1;
    checks++;
    if ({PROM_G, D0} !== {1'b1, 8'h5A}) begin
      errors++; $display("FAIL rm_pre got G=%b D0=%0h want 1 5a", PROM_G, D0);
    end
    #3 RST_N = 1'b0;
    #1;
    checks++;
    if ({PROM_E, PROM_G, BUSY, ACK0, ACK1} !== 5'b0 || D0 !== 8'h00 || D1 !== 8'h00) begin
      errors++; $display("FAIL rm_async got EGBAA=%b D0=%0h D1=%0h want 0", {PROM_E, PROM_G, BUSY, ACK0, ACK1}, D0, D1);
    end
    repeat (3) begin
      @(posedge CLK); #1;
      checks++;
      if ({ACK0, ACK1, BUSY} !== 3'b000) begin
        errors++; $display("FAIL rm_noack got %b want 000", {ACK0, ACK1, BUSY});
      end
    end
    RST_N = 1'b1; A1 = 15'h0022; REQ1 = 1'b1;
    @(posedge CLK); #1;
    REQ1 = 1'b0;
    checks++;
    if (BUSY !== 1'b1 || PROM_A !== 15'h0022) begin
      errors++; $display("FAIL rm_regrant got BUSY=%b A=%0h want 1 22", BUSY, PROM_A);
    end
    repeat (4) @(posedge CLK);
    #1;
    checks++;
    if (ACK1 !== 1'b1 || D1 !== 8'h6D || D0 !== 8'h00) begin
      errors++; $display("FAIL rm_after got ACK1=%b D1=%0h D0=%0h want 1 6d 0", ACK1, D1, D0);
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_wait_one();
    do_reset();
    A0_w1 = 15'h0010; REQ0_w1 = 1'b1;
    @(posedge CLK); #1;
    REQ0_w1 = 1'b0;
    checks++;
    if ({PROM_E_w1, PROM_G_w1} !== 2'b10) begin
      errors++; $display("FAIL w1_setup got EG=%b want 10", {PROM_E_w1, PROM_G_w1});
    end
    @(posedge CLK); #1;
    checks++;
    if ({PROM_E_w1, PROM_G_w1, ACK0_w1} !== 3'b110) begin
      errors++; $display("FAIL w1_access got EGA=%b want 110", {PROM_E_w1, PROM_G_w1, ACK0_w1});
    end
    @(posedge CLK); #1;
    checks++;
    if ({PROM_G_w1, ACK0_w1, ACK1_w1} !== 3'b010 || D0_w1 !== 8'h5A) begin
      errors++; $display("FAIL w1_ack got GAA=%b D0=%0h want 010 5a", {PROM_G_w1, ACK0_w1, ACK1_w1}, D0_w1);
    end
    @(posedge CLK); #1;
    checks++;
    if ({ACK0_w1, BUSY_w1} !== 2'b00) begin
      errors++; $display("FAIL w1_idle got %b want 00", {ACK0_w1, BUSY_w1});
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_tie();
    test_late_requester();
    test_reset_mid_access();
    test_wait_one();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
